// File: rtl/packet_word_streamer.sv
// Purpose: filters UART packets by destination, packs BYTES_PER_WORD bytes (LS first) into words, buffers them in a FIFO.
// Latency: final byte sampled at edge N -> FIFO write at edge N+1 -> opValid at edge N+2 when the output register is empty.
// Backpressure: opValid/opStream hold while !ipReady; a full FIFO drops pushed words and counts them. Optional: `PARTIAL_PAD_EN.

package packet_word_streamer_pkg;
    typedef struct packed {
        logic [7:0] Data;
        logic       Valid;
        logic       SoP;
        logic       EoP;
        logic [7:0] Destination;
    } UART_PACKET;
endpackage

module packet_word_streamer
    import packet_word_streamer_pkg::*;
#(
    parameter int         BYTES_PER_WORD = 2,
    parameter logic [7:0] DEST_ADDR      = 8'h10,
    parameter int         FIFO_DEPTH     = 256,
    localparam int        ADDR_W         = $clog2(FIFO_DEPTH)
)(
    input  logic                        ipClk,
    input  logic                        ipReset,
    input  UART_PACKET                  ipRxStream,
    input  logic                        ipReady,
    output logic [8*BYTES_PER_WORD-1:0] opStream,
    output logic                        opValid,
    output logic [ADDR_W:0]             opFIFO_Size,
    output logic [15:0]                 opDropCount
);

    localparam int                WORD_W    = 8 * BYTES_PER_WORD;
    localparam int                IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = FIFO_DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} stateType;

    // Reset is asserted asynchronously; its release is expected to be synchronous to ipClk.
    stateType               state, stateNext;
    logic [IDX_W-1:0]       byteIdx, idxNext;
    logic [WORD_W-1:0]      wordBuf, wordNext;
    logic                   pushValid, pushNext;
    logic [WORD_W-1:0]      pushWord, pushWordNext;

    logic                   placeEn;
    logic [IDX_W-1:0]       placeIdx;
    logic [WORD_W-1:0]      merged;

    logic [WORD_W-1:0]      mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]      wrPtr, rdPtr;
    logic [ADDR_W:0]        count;
    logic                   fifoFull, fifoEmpty, doWrite, doRead;

    // Input FSM: decide where the current beat's byte lands and whether a word completes.
    always_comb begin
        stateNext    = state;
        idxNext      = byteIdx;
        wordNext     = wordBuf;
        pushNext     = 1'b0;
        pushWordNext = '0;
        placeEn      = 1'b0;
        placeIdx     = '0;
        merged       = '0;

        if (ipRxStream.Valid) begin
            if (ipRxStream.SoP) begin
                // A start-of-packet always restarts word assembly, dropping any partial word.
                idxNext  = '0;
                wordNext = '0;
                if (ipRxStream.Destination == DEST_ADDR) begin
                    placeEn  = 1'b1;
                    placeIdx = '0;
                end else begin
                    stateNext = ipRxStream.EoP ? IDLE : DISCARD;
                end
            end else begin
                case (state)
                    COLLECT: begin
                        placeEn  = 1'b1;
                        placeIdx = byteIdx;
                    end
                    DISCARD: begin
                        if (ipRxStream.EoP) stateNext = IDLE;
                    end
                    default: ;
                endcase
            end
        end

        if (placeEn) begin
            // Lower bytes come from the word under assembly, upper bytes are zero (used for padding).
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (b < int'(placeIdx))
                    merged[8*b +: 8] = wordBuf[8*b +: 8];
                else if (b == int'(placeIdx))
                    merged[8*b +: 8] = ipRxStream.Data;
            end

            if (placeIdx == LAST_IDX) begin
                pushNext     = 1'b1;
                pushWordNext = merged;
                idxNext      = '0;
                wordNext     = '0;
                stateNext    = ipRxStream.EoP ? IDLE : COLLECT;
            end else if (ipRxStream.EoP) begin
`ifdef PARTIAL_PAD_EN
                pushNext     = 1'b1;
                pushWordNext = merged;
`endif
                idxNext      = '0;
                wordNext     = '0;
                stateNext    = IDLE;
            end else begin
                idxNext      = placeIdx + 1'b1;
                wordNext     = merged;
                stateNext    = COLLECT;
            end
        end
    end

    // Input FSM state, assembly buffer and the registered push stage.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state     <= IDLE;
            byteIdx   <= '0;
            wordBuf   <= '0;
            pushValid <= 1'b0;
            pushWord  <= '0;
        end else begin
            state     <= stateNext;
            byteIdx   <= idxNext;
            wordBuf   <= wordNext;
            pushValid <= pushNext;
            pushWord  <= pushWordNext;
        end
    end

    assign fifoFull    = (count == DEPTH_CNT);
    assign fifoEmpty   = (count == '0);
    assign doWrite     = pushValid && !fifoFull;
    assign doRead      = (!opValid || ipReady) && !fifoEmpty;
    assign opFIFO_Size = count;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge ipClk) begin
        if (doWrite) mem[wrPtr] <= pushWord;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + 1'b1;
            if (doRead)  rdPtr <= rdPtr + 1'b1;
            case ({doWrite, doRead})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Saturating count of words lost because the FIFO was full when they arrived.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            opDropCount <= '0;
        end else if (pushValid && fifoFull && (opDropCount != 16'hFFFF)) begin
            opDropCount <= opDropCount + 16'd1;
        end
    end

    // Output register: refills whenever it is empty or being consumed this cycle.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            opStream <= '0;
            opValid  <= 1'b0;
        end else if (doRead) begin
            opStream <= mem[rdPtr];
            opValid  <= 1'b1;
        end else if (ipReady) begin
            opValid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_packet_word_streamer.sv
module tb_packet_word_streamer;
    import packet_word_streamer_pkg::*;

    localparam int DEPTH = 16;

    logic        ipClk = 1'b0;
    logic        ipReset = 1'b1;
    UART_PACKET  ipRxStream;
    logic        ipReady;
    logic [15:0] opStream;
    logic        opValid;
    logic [4:0]  opFIFO_Size;
    logic [15:0] opDropCount;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] expQ[$];

    packet_word_streamer #(
        .BYTES_PER_WORD(2),
        .DEST_ADDR(8'h10),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .ipClk(ipClk),
        .ipReset(ipReset),
        .ipRxStream(ipRxStream),
        .ipReady(ipReady),
        .opStream(opStream),
        .opValid(opValid),
        .opFIFO_Size(opFIFO_Size),
        .opDropCount(opDropCount)
    );

    always #5 ipClk = ~ipClk;

    task automatic sendByte(input logic [7:0] d, input bit sop, input bit eop, input logic [7:0] dest);
        @(negedge ipClk);
        ipRxStream.Data        = d;
        ipRxStream.Valid       = 1'b1;
        ipRxStream.SoP         = sop;
        ipRxStream.EoP         = eop;
        ipRxStream.Destination = dest;
    endtask

    task automatic idleBeat();
        @(negedge ipClk);
        ipRxStream = '0;
    endtask

    // Scoreboard consumer: every accepted output word must be the oldest expected word.
    task automatic runMonitor();
        logic [15:0] expW;
        forever begin
            @(negedge ipClk);
            #1;
            if (!ipReset && opValid && ipReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word got=%h required=none", opStream);
                end else begin
                    expW = expQ.pop_front();
                    if (opStream !== expW) begin
                        failures++;
                        $display("FAIL word got=%h required=%h", opStream, expW);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        ipReset = 1'b1;
        ipReady = 1'b0;
        ipRxStream = '0;
        #12;
        checks++;
        if (opValid !== 1'b0 || opStream !== 16'h0 || opFIFO_Size !== 5'd0 || opDropCount !== 16'd0) begin
            failures++;
            $display("FAIL reset_in v=%b s=%h sz=%0d d=%0d required=0,0,0,0", opValid, opStream, opFIFO_Size, opDropCount);
        end
        @(negedge ipClk);
        ipReset = 1'b0;
        repeat (2) @(negedge ipClk);
        checks++;
        if (opValid !== 1'b0 || opFIFO_Size !== 5'd0) begin
            failures++;
            $display("FAIL reset_out v=%b sz=%0d required=0,0", opValid, opFIFO_Size);
        end
    endtask

    task automatic test_basic();
        ipReady = 1'b1;
        sendByte(8'h34, 1, 0, 8'h10);
        sendByte(8'h12, 0, 0, 8'h10);
        expQ.push_back(16'h1234);
        fork
            begin
                @(posedge ipClk); @(negedge ipClk);
                checks++;
                if (opValid !== 1'b0) begin
                    failures++;
                    $display("FAIL latency_edge1 opValid=%b required=0", opValid);
                end
                @(posedge ipClk); @(negedge ipClk);
                checks++;
                if (opValid !== 1'b0) begin
                    failures++;
                    $display("FAIL latency_edge2 opValid=%b required=0", opValid);
                end
                @(posedge ipClk); @(negedge ipClk);
                checks++;
                if (opValid !== 1'b1 || opStream !== 16'h1234) begin
                    failures++;
                    $display("FAIL latency_edge3 opValid=%b opStream=%h required=1,1234", opValid, opStream);
                end
            end
            begin
                sendByte(8'h78, 0, 0, 8'h10);
                sendByte(8'h56, 0, 1, 8'h10);
                expQ.push_back(16'h5678);
                idleBeat();
            end
        join
        for (int i = 0; i < 30 && expQ.size() != 0; i++) begin
            @(negedge ipClk); #2;
        end
        repeat (4) @(negedge ipClk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL basic_drain pending=%0d required=0", expQ.size());
        end
    endtask

    task automatic test_other_dest();
        sendByte(8'hAA, 1, 0, 8'h20);
        sendByte(8'hBB, 0, 1, 8'h20);
        idleBeat();
        for (int i = 0; i < 4; i++) begin
            @(negedge ipClk);
            checks++;
            if (opValid !== 1'b0 || opFIFO_Size !== 5'd0) begin
                failures++;
                $display("FAIL other_dest cyc=%0d opValid=%b size=%0d required=0,0", i, opValid, opFIFO_Size);
            end
        end
        sendByte(8'h01, 1, 0, 8'h10);
        sendByte(8'h00, 0, 1, 8'h10);
        expQ.push_back(16'h0001);
        idleBeat();
        for (int i = 0; i < 30 && expQ.size() != 0; i++) begin
            @(negedge ipClk); #2;
        end
        repeat (4) @(negedge ipClk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL other_dest_drain pending=%0d required=0", expQ.size());
        end
    endtask

    task automatic test_backpressure();
        @(negedge ipClk);
        ipReady = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            sendByte(8'(i), (i == 0), 0, 8'h10);
            sendByte(8'hA0, 0, (i == DEPTH + 3), 8'h10);
            if (i < DEPTH + 1) expQ.push_back({8'hA0, 8'(i)});
        end
        idleBeat();
        repeat (6) @(negedge ipClk);
        checks++;
        if (opFIFO_Size !== 5'(DEPTH)) begin
            failures++;
            $display("FAIL full_size got=%0d required=%0d", opFIFO_Size, DEPTH);
        end
        checks++;
        if (opDropCount !== 16'd3) begin
            failures++;
            $display("FAIL drop_count got=%0d required=3", opDropCount);
        end
        checks++;
        if (opValid !== 1'b1 || opStream !== 16'hA000) begin
            failures++;
            $display("FAIL held_word opValid=%b opStream=%h required=1,a000", opValid, opStream);
        end
        @(negedge ipClk);
        ipReady = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            #2;
            checks++;
            if (opValid !== 1'b1) begin
                failures++;
                $display("FAIL drain_gap beat=%0d opValid=%b required=1", i, opValid);
            end
            @(negedge ipClk);
        end
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL backpressure_drain pending=%0d required=0", expQ.size());
        end
        repeat (4) @(negedge ipClk);
    endtask

    task automatic test_partial();
        sendByte(8'h11, 1, 0, 8'h10);
        sendByte(8'h22, 0, 0, 8'h10);
        expQ.push_back(16'h2211);
        sendByte(8'h33, 0, 1, 8'h10);
`ifdef PARTIAL_PAD_EN
        expQ.push_back(16'h0033);
`endif
        idleBeat();
        for (int i = 0; i < 30 && expQ.size() != 0; i++) begin
            @(negedge ipClk); #2;
        end
        repeat (4) @(negedge ipClk);
        checks++;
        if (expQ.size() != 0 || opFIFO_Size !== 5'd0) begin
            failures++;
            $display("FAIL partial_drain pending=%0d size=%0d required=0,0", expQ.size(), opFIFO_Size);
        end
    endtask

    task automatic test_sop_mid_word();
        sendByte(8'h11, 1, 0, 8'h10);
        sendByte(8'h44, 1, 0, 8'h10);
        sendByte(8'h33, 0, 1, 8'h10);
        expQ.push_back(16'h3344);
        idleBeat();
        for (int i = 0; i < 30 && expQ.size() != 0; i++) begin
            @(negedge ipClk); #2;
        end
        repeat (4) @(negedge ipClk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL sop_mid_drain pending=%0d required=0", expQ.size());
        end
    endtask

    task automatic test_reset_mid();
        @(negedge ipClk);
        ipReady = 1'b0;
        for (int i = 0; i < DEPTH / 2 + 1; i++) begin
            sendByte(8'(i), (i == 0), 0, 8'h10);
            sendByte(8'hB0, 0, (i == DEPTH / 2), 8'h10);
        end
        idleBeat();
        repeat (6) @(negedge ipClk);
        checks++;
        if (opFIFO_Size !== 5'(DEPTH / 2) || opValid !== 1'b1) begin
            failures++;
            $display("FAIL half_full size=%0d opValid=%b required=%0d,1", opFIFO_Size, opValid, DEPTH / 2);
        end
        ipReset = 1'b1;
        #1;
        checks++;
        if (opValid !== 1'b0 || opStream !== 16'h0 || opFIFO_Size !== 5'd0 || opDropCount !== 16'd0) begin
            failures++;
            $display("FAIL async_reset v=%b s=%h sz=%0d d=%0d required=0,0,0,0", opValid, opStream, opFIFO_Size, opDropCount);
        end
        @(negedge ipClk);
        ipReset = 1'b0;
        ipReady = 1'b1;
        sendByte(8'h02, 1, 0, 8'h10);
        sendByte(8'h01, 0, 1, 8'h10);
        expQ.push_back(16'h0102);
        idleBeat();
        for (int i = 0; i < 30 && expQ.size() != 0; i++) begin
            @(negedge ipClk); #2;
        end
        repeat (4) @(negedge ipClk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL post_reset_drain pending=%0d required=0", expQ.size());
        end
    endtask

    initial begin
        ipRxStream = '0;
        ipReady = 1'b0;
        fork
            runMonitor();
            begin
                #200000;
                $display("FAIL timeout reached required=finish");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_basic();
        test_other_dest();
        test_backpressure();
        test_partial();
        test_sop_mid_word();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
